// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues one instruction-memory read at a time for the current PC and queues the returned words, each with its PC, for decode.
// Latency: grant at T and rvalid at T+k give ir_valid at T+k+1. With IFQ_BYPASS_EN defined, an empty queue presents the word at T+k.
// Backpressure: a queue slot is reserved when the request is issued, so pushes never overflow. ir_ready only drains the head entry.
module instr_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_in,
  output logic          pc_adv,
  input  logic          j_flag,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          ir_valid,
  output logic [DW-1:0] ir_data,
  output logic [AW-1:0] ir_pc,
  input  logic          ir_ready,
  output logic [CW-1:0] q_count
);

  localparam int PW = $clog2(DEPTH);

  // WAIT and DRAIN both mean one read is outstanding.
  // DRAIN means the returning word belongs to a flushed path and is dropped.
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          pc_adv_q, pc_adv_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] data_q [DEPTH];
  logic [AW-1:0] pc_q   [DEPTH];

  logic rsp_push;
  logic fifo_store;
  logic fifo_pop;
  logic fifo_empty;

  assign fifo_empty = (count_q == '0);
  // A response is kept only if it returns in WAIT and no jump happens in the same cycle.
  assign rsp_push   = (state_q == WAIT) && mem_rvalid && !j_flag;
  // A pop on an empty queue, or during a flush, is ignored.
  assign fifo_pop   = !fifo_empty && ir_ready && !j_flag;

`ifdef IFQ_BYPASS_EN
  // Skip storage when the word goes straight to decode in the cycle it arrives.
  assign fifo_store = rsp_push && !(fifo_empty && ir_ready);
`else
  assign fifo_store = rsp_push;
`endif

  // Queue bookkeeping: a jump empties the queue; otherwise apply push and pop.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (j_flag) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (fifo_store) wr_ptr_d = wr_ptr_q + PW'(1);
      if (fifo_pop)   rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(fifo_store) - CW'(fifo_pop);
    end
  end

  // Fetch FSM next state.
  // A jump has priority. The request is then issued one cycle late so that pc_in carries the jump target.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    pc_adv_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // The projected count already includes any pop in this cycle, so a freed slot is reused at once.
        if (!j_flag && (count_d < CW'(DEPTH))) begin
          state_d    = REQ;
          mem_addr_d = pc_in;
        end
      end
      REQ: begin
        if (j_flag) begin
          state_d = mem_gnt ? DRAIN : IDLE;
        end else if (mem_gnt) begin
          state_d  = WAIT;
          pc_adv_d = 1'b1;
        end
      end
      WAIT: begin
        if (j_flag) begin
          state_d = mem_rvalid ? IDLE : DRAIN;
        end else if (mem_rvalid) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (mem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and pointer registers.
  // Reset forgets any outstanding read, so a late response is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_addr_q <= '0;
      pc_adv_q   <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      pc_adv_q   <= pc_adv_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Queue storage.
  // The tag is the held request address, because that address stays stable until the response arrives.
  always_ff @(posedge clk) begin
    if (fifo_store) begin
      data_q[wr_ptr_q] <= mem_rdata;
      pc_q[wr_ptr_q]   <= mem_addr_q;
    end
  end

  assign mem_req  = (state_q == REQ);
  assign mem_addr = mem_addr_q;
  assign pc_adv   = pc_adv_q;
  assign q_count  = count_q;

  // Decode-side view of the queue head.
  // The outputs are zero while the queue is empty, so stale entries never show.
  always_comb begin
    ir_valid = !fifo_empty;
    ir_data  = fifo_empty ? '0 : data_q[rd_ptr_q];
    ir_pc    = fifo_empty ? '0 : pc_q[rd_ptr_q];
`ifdef IFQ_BYPASS_EN
    if (fifo_empty && rsp_push) begin
      ir_valid = 1'b1;
      ir_data  = mem_rdata;
      ir_pc    = mem_addr_q;
    end
`endif
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue.
// The bench acts as the memory and the PC, and drives the decode handshake.
// Inputs change 1 ns after the rising edge, and outputs are checked at that point.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_in;
  logic        pc_adv;
  logic        j_flag;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        ir_valid;
  logic [15:0] ir_data;
  logic [15:0] ir_pc;
  logic        ir_ready;
  logic [2:0]  q_count;

  int checks = 0;
  int errors = 0;
  int adv_cnt = 0;

  instr_fetch_queue dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .pc_adv     (pc_adv),
    .j_flag     (j_flag),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .ir_valid   (ir_valid),
    .ir_data    (ir_data),
    .ir_pc      (ir_pc),
    .ir_ready   (ir_ready),
    .q_count    (q_count)
  );

  always #5 clk = ~clk;

  // Count PC-advance strobes away from the active edge.
  always @(negedge clk) if (pc_adv === 1'b1) adv_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete fetch: grant for 1 cycle, respond the next cycle, then let the PC advance.
  task automatic fetch(input logic [15:0] d, input logic pop);
    int n = 0;
    while (mem_req !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    check("fetch_req", 32'(mem_req), 1);
    mem_gnt = 1'b1;
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    ir_ready   = pop;
    step();
    mem_rvalid = 1'b0;
    ir_ready   = 1'b0;
    pc_in      = pc_in + 16'd1;
    step();
  endtask

  initial begin
    rst = 1'b1; pc_in = 16'h0000; j_flag = 1'b0; mem_gnt = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = 16'h0000; ir_ready = 1'b0;

    // 1: reset values, then the first request after release
    step(); step();
    check("rst_mem_req",  32'(mem_req),  0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_pc_adv",   32'(pc_adv),   0);
    check("rst_ir_valid", 32'(ir_valid), 0);
    check("rst_ir_data",  32'(ir_data),  0);
    check("rst_ir_pc",    32'(ir_pc),    0);
    check("rst_q_count",  32'(q_count),  0);
    rst = 1'b0;
    step();
    check("first_req",  32'(mem_req),  1);
    check("first_addr", 32'(mem_addr), 16'h0000);

    // 2: fill the queue with decode stalled, then free one slot
    for (int i = 0; i < 4; i++) fetch(16'hA5A0 + 16'(i), 1'b0);
    check("full_count",   32'(q_count),  4);
    check("full_no_req",  32'(mem_req),  0);
    check("full_adv_cnt", 32'(adv_cnt),  4);
    check("full_head_d",  32'(ir_data),  16'hA5A0);
    check("full_head_pc", 32'(ir_pc),    16'h0000);
    step();
    check("full_still_no_req", 32'(mem_req), 0);
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
    check("pop_req",     32'(mem_req),  1);
    check("pop_addr",    32'(mem_addr), 16'h0004);
    check("pop_count",   32'(q_count),  3);
    check("pop_head_pc", 32'(ir_pc),    16'h0001);
    check("pop_head_d",  32'(ir_data),  16'hA5A1);

    // 3: two entries queued, jump while a read is outstanding
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
    check("two_count", 32'(q_count), 2);
    check("two_pc",    32'(ir_pc),   16'h0002);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    j_flag  = 1'b1;
    pc_in   = 16'h0040;
    step();
    j_flag = 1'b0;
    check("flush_count", 32'(q_count),  0);
    check("flush_valid", 32'(ir_valid), 0);
    check("flush_adv",   32'(pc_adv),   0);
    mem_rvalid = 1'b1;
    mem_rdata  = 16'h1234;
    step();
    mem_rvalid = 1'b0;
    check("drop_count", 32'(q_count),  0);
    check("drop_valid", 32'(ir_valid), 0);
    check("drop_noreq", 32'(mem_req),  0);
    step();
    check("jump_req",     32'(mem_req),  1);
    check("jump_addr",    32'(mem_addr), 16'h0040);
    check("jump_adv_cnt", 32'(adv_cnt),  5);

    // 3b: jump in the same cycle as the grant suppresses the PC advance
    mem_gnt = 1'b1;
    j_flag  = 1'b1;
    pc_in   = 16'h0080;
    step();
    mem_gnt = 1'b0;
    j_flag  = 1'b0;
    check("gntj_adv",   32'(pc_adv),  0);
    check("gntj_noreq", 32'(mem_req), 0);
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hDEAD;
    step();
    mem_rvalid = 1'b0;
    check("gntj_count",   32'(q_count), 0);
    check("gntj_adv_cnt", 32'(adv_cnt), 5);
    step();
    check("gntj_addr", 32'(mem_addr), 16'h0080);

    // 3c: jump while requesting without a grant drops the request
    j_flag = 1'b1;
    pc_in  = 16'h0010;
    step();
    j_flag = 1'b0;
    check("reqj_noreq", 32'(mem_req), 0);
    step();
    check("reqj_addr", 32'(mem_addr), 16'h0010);

    // 4: push and pop in the same cycle keep the count steady
    fetch(16'h0100, 1'b0);
    check("pp0_count", 32'(q_count), 1);
    check("pp0_pc",    32'(ir_pc),   16'h0010);
    check("pp0_data",  32'(ir_data), 16'h0100);
    fetch(16'h0101, 1'b1);
    check("pp1_count", 32'(q_count), 1);
    check("pp1_pc",    32'(ir_pc),   16'h0011);
    fetch(16'h0102, 1'b1);
    check("pp2_count", 32'(q_count), 1);
    check("pp2_pc",    32'(ir_pc),   16'h0012);
    check("pp2_data",  32'(ir_data), 16'h0102);

    // 5: reset during WAIT; the late response must be ignored
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    rst     = 1'b1;
    step();
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 16'h5555;
    step();
    mem_rvalid = 1'b0;
    check("rstw_valid", 32'(ir_valid), 0);
    check("rstw_count", 32'(q_count),  0);
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
    check("empty_pop_count", 32'(q_count),  0);
    check("rstw_valid2",     32'(ir_valid), 0);

    // 6: empty-queue response, with and without the bypass path
    check("bp_req", 32'(mem_req), 1);
    mem_gnt = 1'b1;
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hBEEF;
    ir_ready   = 1'b1;
    #1;
`ifdef IFQ_BYPASS_EN
    check("bp_valid", 32'(ir_valid), 1);
    check("bp_data",  32'(ir_data),  16'hBEEF);
    check("bp_pc",    32'(ir_pc),    16'h0013);
    step();
    mem_rvalid = 1'b0;
    ir_ready   = 1'b0;
    check("bp_count", 32'(q_count),  0);
    check("bp_after", 32'(ir_valid), 0);
`else
    check("nb_valid_early", 32'(ir_valid), 0);
    step();
    mem_rvalid = 1'b0;
    ir_ready   = 1'b0;
    check("nb_valid", 32'(ir_valid), 1);
    check("nb_data",  32'(ir_data),  16'hBEEF);
    check("nb_pc",    32'(ir_pc),    16'h0013);
    check("nb_count", 32'(q_count),  1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
